io_responder: RTL and testbench

Memory-mapped I/O responder for the Riscv151 core. Decodes CPU loads and stores to the I/O region (0x8000_0000 and up), buffers UART traffic in RX and TX FIFOs, and keeps cycle and retired-instruction counters. It sits beside dmem/bios_mem on the stage-2 address bus. It feeds mem_read_controller's io_data_in and drives the on-chip uart's ready/valid ports.

---
 rtl/io_map_pkg.sv | 12 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/io_responder.sv | 104 ++++++++++
 tb/tb_io_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Address map and status-bit layout shared by the I/O responder and its bench.
package io_map_pkg;
  localparam logic [7:0] IO_STATUS  = 8'h00;
  localparam logic [7:0] IO_RX_DATA = 8'h04;
  localparam logic [7:0] IO_TX_DATA = 8'h08;
  localparam logic [7:0] IO_CYCLE   = 8'h10;
  localparam logic [7:0] IO_INST    = 8'h14;
  localparam logic [7:0] IO_CNT_RST = 8'h18;

  localparam int STAT_TX_NOTFULL  = 0;
  localparam int STAT_RX_NONEMPTY = 1;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; push refused when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // Flags are taken from the pre-edge count, so a full FIFO refuses a push even alongside a pop.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: UART RX/TX FIFOs plus cycle and retired-instruction counters.
module io_responder
  import io_map_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  input  logic        io_re,
  output logic [31:0] io_rdata,
  input  logic        inst_retire,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);
  logic [7:0]  offs;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]  rx_head;
  logic        rx_pop, tx_push, cnt_clr;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] status;
  logic        unused_bits;

  assign offs        = io_addr[7:0];
  assign unused_bits = ^{io_addr[31:8], io_wdata[31:8]};

  assign rx_pop  = io_re && (offs == IO_RX_DATA);
  assign tx_push = io_we && (offs == IO_TX_DATA);
  assign cnt_clr = io_we && (offs == IO_CNT_RST);

  assign uart_rx_ready = !rx_full;
  assign uart_tx_valid = !tx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_rx_valid),
    .din   (uart_rx_data),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (io_wdata[7:0]),
    .pop   (uart_tx_ready),
    .dout  (uart_tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_comb begin
    status                   = '0;
    status[STAT_TX_NOTFULL]  = !tx_full;
    status[STAT_RX_NONEMPTY] = !rx_empty;
  end

  always_comb begin
    rdata_d = '0;
    case (offs)
      IO_STATUS:  rdata_d = status;
      IO_RX_DATA: rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
      IO_CYCLE:   rdata_d = cycle_q;
      IO_INST:    rdata_d = inst_q;
      default:    rdata_d = '0;
    endcase
  end

  // A counter-reset write overrides any increment landing on the same edge.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    inst_d  = inst_q + {31'h0, inst_retire};
    if (cnt_clr) begin
      cycle_d = '0;
      inst_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      cycle_q <= '0;
      inst_q  <= '0;
    end else begin
      if (io_re) rdata_q <= rdata_d;
      cycle_q <= cycle_d;
      inst_q  <= inst_d;
    end
  end

  assign io_rdata = rdata_q;
endmodule

// File: tb/tb_io_responder.sv
// Randomized and directed bench for io_responder against a queue-based model of the register map.
module tb_io_responder;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] io_addr = '0;
  logic [31:0] io_wdata = '0;
  logic        io_we = 1'b0;
  logic        io_re = 1'b0;
  logic [31:0] io_rdata;
  logic        inst_retire = 1'b0;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;

  io_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .io_addr       (io_addr),
    .io_wdata      (io_wdata),
    .io_we         (io_we),
    .io_re         (io_re),
    .io_rdata      (io_rdata),
    .inst_retire   (inst_retire),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: FIFO contents as queues, counters as plain integers.
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic [31:0] m_cyc   = 0;
  logic [31:0] m_inst  = 0;
  logic [31:0] m_rdata = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_cyc   = 0;
    m_inst  = 0;
    m_rdata = 0;
  endtask

  // One clock: predict from pre-edge inputs/state, advance, then compare outputs.
  task automatic tick();
    logic [7:0] a;
    bit tx_push, tx_pop, rx_push, rx_pop, clr;
    logic [31:0] rd;
    logic [7:0] wb;
    logic       was_run;
    a = io_addr[7:0];
    wb = io_wdata[7:0];
    was_run = rst;
    tx_push = io_we && a == 8'h08 && m_tx.size() < DEPTH;
    tx_pop  = uart_tx_ready && m_tx.size() > 0;
    rx_push = uart_rx_valid && m_rx.size() < DEPTH;
    rx_pop  = io_re && a == 8'h04 && m_rx.size() > 0;
    clr     = io_we && a == 8'h18;
    rd = 0;
    case (a)
      8'h00: rd = {30'h0, m_rx.size() > 0, m_tx.size() < DEPTH};
      8'h04: rd = (m_rx.size() > 0) ? {24'h0, m_rx[0]} : 32'h0;
      8'h10: rd = m_cyc;
      8'h14: rd = m_inst;
      default: rd = 0;
    endcase
    if (rst && m_tx.size() > 0) check_eq("tx_head", {24'h0, uart_tx_data}, {24'h0, m_tx[0]});
    @(posedge clk);
    #1;
    if (was_run) begin
      if (io_re) m_rdata = rd;
      if (tx_pop) void'(m_tx.pop_front());
      if (tx_push) m_tx.push_back(wb);
      if (rx_pop) void'(m_rx.pop_front());
      if (rx_push) m_rx.push_back(uart_rx_data);
      if (clr) begin
        m_cyc  = 0;
        m_inst = 0;
      end else begin
        m_cyc  = m_cyc + 1;
        m_inst = m_inst + inst_retire;
      end
    end
    check_eq("rdata", io_rdata, m_rdata);
    check_eq("tx_valid", {31'h0, uart_tx_valid}, {31'h0, m_tx.size() > 0});
    check_eq("rx_ready", {31'h0, uart_rx_ready}, {31'h0, m_rx.size() < DEPTH});
  endtask

  task automatic idle();
    io_we = 0; io_re = 0; inst_retire = 0; uart_rx_valid = 0;
  endtask

  task automatic rd(input logic [7:0] a);
    idle(); io_re = 1; io_addr = {24'h8000_00, a}; tick(); io_re = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    idle(); io_we = 1; io_addr = {24'h8000_00, a}; io_wdata = {24'h0, d}; tick(); io_we = 0;
  endtask

  initial begin
    logic [7:0] got[$];
    bit         ret[100];
    int         j;
    bit         tb;

    // Reset state
    #2;
    check_eq("rst_rdata", io_rdata, 0);
    check_eq("rst_tx_valid", {31'h0, uart_tx_valid}, 0);
    check_eq("rst_rx_ready", {31'h0, uart_rx_ready}, 1);
    model_reset();
    tick(); tick();
    rst = 1;
    tick();
    rd(8'h00);
    check_eq("status_after_reset", io_rdata, 32'h1);

    // Two TX bytes held, then drained
    uart_tx_ready = 0;
    wr(8'h08, 8'h41);
    wr(8'h08, 8'h42);
    idle();
    check_eq("tx_valid_held", {31'h0, uart_tx_valid}, 1);
    check_eq("tx_first_byte", {24'h0, uart_tx_data}, 32'h41);
    uart_tx_ready = 1;
    got.delete();
    for (int i = 0; i < 2; i++) begin
      if (uart_tx_valid) got.push_back(uart_tx_data);
      tick();
    end
    uart_tx_ready = 0;
    check_eq("tx_two_count", got.size(), 2);
    check_eq("tx_two_order", {16'h0, got[0], got[1]}, 32'h4142);
    check_eq("tx_drained", {31'h0, uart_tx_valid}, 0);

    // Overfill TX: ninth byte dropped
    for (int i = 0; i < 9; i++) begin
      wr(8'h08, 8'(8'h30 + i));
      if (i == 7) begin
        rd(8'h00);
        check_eq("tx_full_status", {31'h0, io_rdata[0]}, 0);
      end
    end
    idle();
    uart_tx_ready = 1;
    got.delete();
    for (int i = 0; i < 12; i++) begin
      if (uart_tx_valid) got.push_back(uart_tx_data);
      tick();
    end
    uart_tx_ready = 0;
    check_eq("tx_drop_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++) check_eq("tx_drop_order", {24'h0, got[i]}, 32'h30 + i);

    // RX push/pop and fill
    idle(); uart_rx_valid = 1; uart_rx_data = 8'h55; tick(); idle();
    rd(8'h04);
    check_eq("rx_first_read", io_rdata, 32'h55);
    rd(8'h00);
    check_eq("rx_empty_status", {31'h0, io_rdata[1]}, 0);
    rd(8'h04);
    check_eq("rx_empty_read", io_rdata, 0);
    for (int i = 0; i < 9; i++) begin
      idle(); uart_rx_valid = 1; uart_rx_data = 8'(8'hA0 + i); tick();
    end
    idle();
    check_eq("rx_full_ready", {31'h0, uart_rx_ready}, 0);
    for (int i = 0; i < 8; i++) begin
      rd(8'h04);
      check_eq("rx_drain", io_rdata, 32'hA0 + i);
    end

    // Counters: 100 cycles with 37 retires
    for (int i = 0; i < 100; i++) ret[i] = (i < 37);
    for (int i = 99; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tb = ret[i]; ret[i] = ret[j]; ret[j] = tb;
    end
    wr(8'h18, 8'h00);
    for (int i = 0; i < 100; i++) begin
      idle(); inst_retire = ret[i]; tick();
    end
    rd(8'h10);
    check_eq("cycle_100", io_rdata, 32'd100);
    rd(8'h14);
    check_eq("inst_37", io_rdata, 32'd37 + 32'(ret[0] & 1'b0));
    idle(); io_we = 1; io_addr = 32'h8000_0018; inst_retire = 1; tick();
    rd(8'h10);
    check_eq("cycle_cleared", io_rdata, 0);
    rd(8'h14);
    check_eq("inst_cleared", io_rdata, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] offs_tab [8];
      offs_tab = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h1C};
      io_addr       = {24'h8000_00, offs_tab[$urandom_range(7, 0)]};
      if (io_addr[7:0] == 8'h18 && $urandom_range(15, 0) != 0) io_addr[7:0] = 8'h04;
      io_wdata      = $urandom;
      io_re         = ($urandom_range(2, 0) == 0);
      io_we         = ($urandom_range(2, 0) == 0);
      inst_retire   = $urandom_range(1, 0);
      uart_tx_ready = ($urandom_range(3, 0) == 0);
      uart_rx_valid = ($urandom_range(2, 0) == 0);
      uart_rx_data  = 8'($urandom);
      tick();
    end
    idle();
    uart_tx_ready = 0;

    // Reset mid-drain
    for (int i = 0; i < 4; i++) wr(8'h08, 8'(8'h60 + i));
    rd(8'h00);
    uart_tx_ready = 1;
    tick();
    rst = 0;
    #1;
    check_eq("midrst_tx_valid", {31'h0, uart_tx_valid}, 0);
    check_eq("midrst_rdata", io_rdata, 0);
    check_eq("midrst_rx_ready", {31'h0, uart_rx_ready}, 1);
    model_reset();
    uart_tx_ready = 0;
    tick(); tick();
    rst = 1;
    tick();
    rd(8'h10);
    check_eq("cycle_after_rst", io_rdata, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
